// File: rtl/bcd_display_scan_if.sv
// Interface between the BCD count source and the 7-segment scan driver.
// The master drives the count, DP enables and blank, and the slave drives the pins.
interface bcd_display_scan_if;
  logic [15:0] cntr_in;
  logic [3:0]  dp_sel;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output cntr_in, dp_sel, blank, input an, seg, dp);
  modport slave  (input cntr_in, dp_sel, blank, output an, seg, dp);
endinterface

// File: rtl/bcd_display_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display fed by a BCD count.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros of the snapshot (digit 0 always shown).
module bcd_display_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int PW       = 17
) (
  input logic              clk,
  input logic              rst,
  bcd_display_scan_if.slave bus
);

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  // Active-low segment patterns {g,f,e,d,c,b,a}; non-BCD codes render as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  logic [PW-1:0] pre_p0;
  logic [1:0]    idx_p0;
  logic [15:0]   snap_p0;
  logic          tick_p0;

  logic [3:0]    digit_p0;
  logic          lz_p0;
  logic          dark_p0;
  logic [3:0]    an_nx;
  logic [6:0]    seg_nx;
  logic          dp_nx;

  logic [3:0]    an_p1;
  logic [6:0]    seg_p1;
  logic          dp_p1;

  assign tick_p0 = (pre_p0 == PRE_LAST);

  // Stage p0: prescaler, slot index and frame snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_p0  <= '0;
      idx_p0  <= 2'd0;
      snap_p0 <= 16'h0000;
    end else if (tick_p0) begin
      pre_p0 <= '0;
      idx_p0 <= idx_p0 + 2'd1;
      // Load on the 3->0 wrap so a whole frame shows one consistent count
      if (idx_p0 == 2'd3) snap_p0 <= bus.cntr_in;
    end else begin
      pre_p0 <= pre_p0 + 1'b1;
    end
  end

  assign digit_p0 = snap_p0[{idx_p0, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_p0 = 1'b0;
    case (idx_p0)
      2'd3:    lz_p0 = (snap_p0[15:12] == 4'd0);
      2'd2:    lz_p0 = (snap_p0[15:8]  == 8'd0);
      2'd1:    lz_p0 = (snap_p0[15:4]  == 12'd0);
      default: lz_p0 = 1'b0;
    endcase
  end
`else
  assign lz_p0 = 1'b0;
`endif

  always_comb begin
    dark_p0 = bus.blank | lz_p0;
    an_nx   = 4'b1111;
    seg_nx  = 7'h7F;
    dp_nx   = 1'b1;
    if (!dark_p0) begin
      an_nx  = ~(4'b0001 << idx_p0);
      seg_nx = seg_decode(digit_p0);
      dp_nx  = ~bus.dp_sel[idx_p0];
    end
  end

  // Stage p1: registered pin drivers, dark out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      an_p1  <= 4'b1111;
      seg_p1 <= 7'h7F;
      dp_p1  <= 1'b1;
    end else begin
      an_p1  <= an_nx;
      seg_p1 <= seg_nx;
      dp_p1  <= dp_nx;
    end
  end

  assign bus.an  = an_p1;
  assign bus.seg = seg_p1;
  assign bus.dp  = dp_p1;

endmodule
